// File: rtl/regfile_write_arbiter.sv
// Write-port controller for the 32x32 register file: round-robin arbitration between
// ALU (A) and load/aux (B) writeback, plus a sweep that zeroes r1..r(NUM_REGS-1).
module regfile_write_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_start,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              regWrite,
  output logic              busy,
  output logic              clear_done
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              ptr, ptr_nxt;          // 0: A wins a tie, 1: B wins a tie
  logic              grant_a, grant_b;
  logic [ADDR_W-1:0] write_reg_nxt;
  logic [DATA_W-1:0] write_data_nxt;
  logic              reg_write_nxt, busy_nxt, clear_done_nxt;

  // State and write-port registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CLEAR;
      cnt        <= FIRST_IDX;
      ptr        <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      regWrite   <= 1'b0;
      busy       <= 1'b1;
      clear_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ptr        <= ptr_nxt;
      write_reg  <= write_reg_nxt;
      write_data <= write_data_nxt;
      regWrite   <= reg_write_nxt;
      busy       <= busy_nxt;
      clear_done <= clear_done_nxt;
    end
  end

  // Next-state: clear sweep or one arbitrated transfer per edge
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    ptr_nxt        = ptr;
    write_reg_nxt  = write_reg;
    write_data_nxt = write_data;
    reg_write_nxt  = 1'b0;
    busy_nxt       = busy;
    clear_done_nxt = 1'b0;
    case (state)
      CLEAR: begin
        reg_write_nxt  = 1'b1;
        write_reg_nxt  = cnt;
        write_data_nxt = '0;
        cnt_nxt        = cnt + FIRST_IDX;
        if (cnt == LAST_IDX) begin
          clear_done_nxt = 1'b1;
          busy_nxt       = 1'b0;
          state_nxt      = RUN;
        end
      end
      RUN: begin
        if (clear_start) begin
          // One idle edge before the sweep's first write
          state_nxt = CLEAR;
          cnt_nxt   = FIRST_IDX;
          busy_nxt  = 1'b1;
        end else if (grant_a) begin
          write_reg_nxt  = a_reg;
          write_data_nxt = a_data;
          reg_write_nxt  = (a_reg != '0);
          if (b_valid) ptr_nxt = 1'b1;
        end else if (grant_b) begin
          write_reg_nxt  = b_reg;
          write_data_nxt = b_data;
          reg_write_nxt  = (b_reg != '0);
          if (a_valid) ptr_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output: combinational grants, only while running and no clear is requested
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst && state == RUN && !clear_start) begin
      if (a_valid && (!b_valid || !ptr)) grant_a = 1'b1;
      else if (b_valid)                  grant_b = 1'b1;
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  a_b_exclusive: assert property (@(posedge clk) disable iff (rst) !(a_ready && b_ready));
  a_ready_valid: assert property (@(posedge clk) disable iff (rst) a_ready |-> a_valid);
  b_ready_valid: assert property (@(posedge clk) disable iff (rst) b_ready |-> b_valid);
  no_x_control:  assert property (@(posedge clk) disable iff (rst) !$isunknown({regWrite, clear_done}));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: behavioural model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_regfile_write_arbiter;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear_start;
  logic              a_valid, b_valid;
  logic [ADDR_W-1:0] a_reg, b_reg;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_ready, b_ready;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              regWrite, busy, clear_done;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  regfile_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst), .clear_start(clear_start),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .write_reg(write_reg), .write_data(write_data), .regWrite(regWrite),
    .busy(busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register file fed by the DUT's write port
  logic [DATA_W-1:0] dut_rf [NUM_REGS];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) dut_rf[k] <= '0;
    end else if (regWrite) begin
      dut_rf[write_reg] <= write_data;
    end
  end

  // Behavioural model: m_left counts clear writes still owed (0 = running)
  int                m_left;
  bit                m_ptr_b;
  logic [ADDR_W-1:0] m_wreg;
  logic [DATA_W-1:0] m_wdata;
  logic              m_we, m_busy, m_done;
  logic [1:0]        m_rdy;   // {b, a}

  always_comb begin
    m_rdy = 2'b00;
    if (!rst && m_left == 0 && !clear_start) begin
      if (a_valid && b_valid) m_rdy = m_ptr_b ? 2'b10 : 2'b01;
      else                    m_rdy = {b_valid, a_valid};
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left  <= NUM_REGS - 1;
      m_ptr_b <= 1'b0;
      m_wreg  <= '0;
      m_wdata <= '0;
      m_we    <= 1'b0;
      m_busy  <= 1'b1;
      m_done  <= 1'b0;
    end else if (m_left > 0) begin
      m_we    <= 1'b1;
      m_wreg  <= ADDR_W'(NUM_REGS - m_left);
      m_wdata <= '0;
      m_left  <= m_left - 1;
      m_done  <= (m_left == 1);
      m_busy  <= (m_left != 1);
    end else begin
      m_done <= 1'b0;
      if (clear_start) begin
        m_left <= NUM_REGS - 1;
        m_busy <= 1'b1;
        m_we   <= 1'b0;
      end else if (m_rdy[0]) begin
        m_wreg  <= a_reg;
        m_wdata <= a_data;
        m_we    <= (a_reg != 0);
        if (b_valid) m_ptr_b <= 1'b1;
      end else if (m_rdy[1]) begin
        m_wreg  <= b_reg;
        m_wdata <= b_data;
        m_we    <= (b_reg != 0);
        if (a_valid) m_ptr_b <= 1'b0;
      end else begin
        m_we <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_a_ready",    a_ready,    m_rdy[0]);
      chk("mdl_b_ready",    b_ready,    m_rdy[1]);
      chk("mdl_regWrite",   regWrite,   m_we);
      chk("mdl_write_reg",  write_reg,  m_wreg);
      chk("mdl_write_data", write_data, m_wdata);
      chk("mdl_busy",       busy,       m_busy);
      chk("mdl_clear_done", clear_done, m_done);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clear_start = 1'b0;
    a_valid = 1'b0; a_reg = '0; a_data = '0;
    b_valid = 1'b0; b_reg = '0; b_data = '0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regWrite", regWrite, 0);
    chk("rst_busy", busy, 1);
    chk("rst_write_reg", write_reg, 0);
    rst = 1'b0;

    // Post-reset sweep: r1..r31 zeroed on 31 consecutive edges
    for (int i = 1; i < NUM_REGS; i++) begin
      tick();
      chk("clr_write_reg", write_reg, i);
      chk("clr_regWrite", regWrite, 1);
      chk("clr_write_data", write_data, 0);
      chk("clr_done", clear_done, i == NUM_REGS - 1);
      chk("clr_busy", busy, i != NUM_REGS - 1);
      chk("clr_a_ready", a_ready, 0);
    end

    // A only
    a_valid = 1'b1; a_reg = 5'd2; a_data = 32'hF0F0F0F0;
    #1 chk("a_only_ready", a_ready, 1);
    tick();
    chk("a_only_reg", write_reg, 2);
    chk("a_only_data", write_data, 32'hF0F0F0F0);
    chk("a_only_we", regWrite, 1);
    a_valid = 1'b0;
    tick();
    chk("a_only_rf2", dut_rf[2], 32'hF0F0F0F0);
    chk("idle_we", regWrite, 0);

    // Both valid: alternate A, B, A, B
    a_valid = 1'b1; a_reg = 5'd1; a_data = 32'hFFFF0000;
    b_valid = 1'b1; b_reg = 5'd2; b_data = 32'hFFFFFFFF;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_a_ready", a_ready, (k % 2) == 0);
      chk("rr_b_ready", b_ready, (k % 2) == 1);
      tick();
      chk("rr_we", regWrite, 1);
      chk("rr_write_reg", write_reg, ((k % 2) == 0) ? 1 : 2);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    chk("rr_rf1", dut_rf[1], 32'hFFFF0000);
    chk("rr_rf2", dut_rf[2], 32'hFFFFFFFF);

    // Write to r0 is accepted but suppressed
    a_valid = 1'b1; a_reg = 5'd0; a_data = 32'h12345678;
    #1 chk("r0_ready", a_ready, 1);
    tick();
    chk("r0_we", regWrite, 0);
    chk("r0_write_data", write_data, 32'h12345678);
    a_valid = 1'b0;
    tick();
    chk("r0_rf0", dut_rf[0], 0);

    // A streaming, then clear_start preempts it
    a_valid = 1'b1; a_reg = 5'd3; a_data = 32'hA5A5A5A5;
    repeat (2) tick();
    chk("stream_reg", write_reg, 3);
    clear_start = 1'b1; a_reg = 5'd4; a_data = 32'h5A5A5A5A;
    #1 chk("cs_a_ready", a_ready, 0);
    tick();
    clear_start = 1'b0;
    chk("cs_busy", busy, 1);
    chk("cs_we", regWrite, 0);
    for (int i = 1; i < NUM_REGS; i++) begin
      chk("cs_sweep_a_ready", a_ready, 0);
      tick();
      chk("cs_sweep_reg", write_reg, i);
      chk("cs_sweep_done", clear_done, i == NUM_REGS - 1);
    end
    chk("cs_after_a_ready", a_ready, 1);
    tick();
    chk("cs_pending_reg", write_reg, 4);
    chk("cs_pending_data", write_data, 32'h5A5A5A5A);
    chk("cs_pending_we", regWrite, 1);
    a_valid = 1'b0;
    tick();
    chk("cs_rf1", dut_rf[1], 0);
    chk("cs_rf3", dut_rf[3], 0);
    chk("cs_rf4", dut_rf[4], 32'h5A5A5A5A);

    // Reset in the middle of a sweep restarts it from r1
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    chk("mid_write_reg", write_reg, 9);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we", regWrite, 0);
    chk("mid_rst_reg", write_reg, 0);
    chk("mid_rst_busy", busy, 1);
    tick();
    rst = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      tick();
      chk("re_sweep_reg", write_reg, i);
      chk("re_sweep_we", regWrite, 1);
    end
    tick();
    chk("end_we", regWrite, 0);
    chk("end_busy", busy, 0);
    chk("end_done", clear_done, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
